axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
AXI4 subordinate (responder) with an internal word-addressed memory array. It is the far end of the DMA controller's AXI4 master port. It serves as the memory endpoint for integration benches and for on-chip scratch RAM. It accepts one read burst and one write burst concurrently, supports FIXED and INCR bursts, and returns SLVERR for unsupported or out-of-range accesses.

Parameters:
AXI_ID_WIDTH, 4, width of ARID/RID/AWID/BID
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 32, data width; only 32 is supported
MEM_WORDS, 1024, depth of the memory in 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 2, idle cycles between AR acceptance and the first RVALID; 0 is legal

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address channel
s_axi_arvalid  in  1;  s_axi_arready  out  1
s_axi_rid/rdata/rresp  out  ID/32/2;  s_axi_rlast/rvalid  out  1;  s_axi_rready  in  1
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address channel
s_axi_awvalid  in  1;  s_axi_awready  out  1
s_axi_wdata  in  32;  s_axi_wstrb  in  4;  s_axi_wlast/wvalid  in  1;  s_axi_wready  out  1
s_axi_bid/bresp  out  ID/2;  s_axi_bvalid  out  1;  s_axi_bready  in  1
err_count  out  8  saturating count of SLVERR responses issued (R beats plus B)

Behaviour:
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, bvalid=0, rresp/bresp/rid/bid=0, rdata=0, err_count=0. Both FSMs reset to IDLE. Memory contents are not reset.
- Reset mid-burst aborts all bursts immediately; no response is completed.
- Read FSM, R_IDLE -> R_WAIT -> R_DATA:
  - R_IDLE: arready=1. An AR handshake captures id, addr, len, size and burst, clears the beat counter and the latency counter. Next state is R_WAIT, or R_DATA if READ_LATENCY=0.
  - R_WAIT: arready=0. After READ_LATENCY cycles, go to R_DATA.
  - R_DATA: rvalid=1; rid=captured id; rlast=(beat==len). rdata=mem[(addr-BASE_ADDR)>>2], read combinationally from the array.
  - On an rvalid&&rready handshake: beat+1 and the address advances. After the handshake with rlast=1, go to R_IDLE with rvalid=0 the next cycle.
  - rvalid, rdata, rresp and rlast are held stable while rready=0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. W data presented before AW is not accepted.
  - AW handshake: capture fields, clear the beat counter and the error flag, go to W_DATA.
  - W_DATA: wready=1. On each W handshake, for each strobe bit i set and the beat in range, write byte lane i of mem.
  - An out-of-range or unsupported beat is discarded and sets the error flag.
  - wlast != (beat==len) sets the error flag.
  - The handshake with beat==len goes to W_RESP. The FSM is driven by beat count, not by wlast.
  - W_RESP: bvalid=1, bid=captured id, bresp=SLVERR if the error flag is set, else OKAY. A bready handshake returns to W_IDLE.
- Address and burst rules, shared by both channels:
  - Address step is 1<<size. INCR adds the step per beat; FIXED holds the address. The address is 32-bit wrapping; 4KB crossing is not checked.
  - A beat is in range iff addr>=BASE_ADDR and ((addr-BASE_ADDR)>>2)<MEM_WORDS.
  - Unsupported requests are burst==WRAP or reserved, and size>2. Every beat of such a burst gets SLVERR, read data 0, and no writes.
  - Narrow reads return the full word; narrow writes rely on wstrb.
  - RRESP is per beat: OKAY (2'b00) or SLVERR (2'b10).
- Read and write to the same word: a write committed at edge N is visible on rdata from cycle N+1.
- err_count increments by 1 per SLVERR R beat handshake and per SLVERR B handshake, saturating at 255. A simultaneous R and B SLVERR in the same cycle adds 2.

Decomposition:
- dma_pkg holds: RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP constants, rd_state_e/wr_state_e enums, and AXI_ID_WIDTH/AXI_ADDR_WIDTH defaults.
- One sub-module: axi_burst_addr_gen. Inputs are addr, size and burst; outputs are next_addr, word_index, in_range and unsupported. It is instantiated once per channel.

Test Plan:
- INCR write awaddr=0x100, awlen=3, size=2, data A0..A3, wstrb=F, followed by an INCR read of the same range -> bresp=OKAY; rdata A0,A1,A2,A3 with rlast on beat 3; first rvalid exactly 2 cycles after the AR handshake.
- Write 0x11223344 at 0x40, then write wdata=0xAABBCCDD with wstrb=4'b0101, then read 0x40 -> 0x11BB33DD.
- FIXED read of len=3 at 0x20 -> 4 beats, all carrying mem[8].
- Read at BASE_ADDR+4*MEM_WORDS-4 with len=1 -> beat0 OKAY, beat1 SLVERR with rdata 0; err_count=1.
- rready toggled 1-0-0-1 during a read burst -> rdata and rlast stay stable while stalled. Concurrently, a write burst completes with correct data and no interference.
- aresetn pulsed low mid-write -> all outputs return to their reset values asynchronously. A subsequent AW is accepted with arready=awready=1.

Source files
------------

// File: rtl/axi4_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_slave_mem_pkg
//  Description : Shared constants and state types for the AXI4 memory
//                responder and its burst address generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4_slave_mem_pkg;

  localparam int AXI_ID_WIDTH_DEF   = 4;
  localparam int AXI_ADDR_WIDTH_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/axi4_slave_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_slave_mem_if
//  Description : AXI4 read/write channel bundle with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) ();

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface
`default_nettype wire

// File: rtl/axi4_slave_mem_burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_addr_gen
//  Description : Per-beat address decode for one AXI channel: next beat
//                address, memory word index, range and support checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
  import axi4_slave_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_WORDS = 1024,
  parameter int                IDX_W     = $clog2(MEM_WORDS),
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [IDX_W-1:0]  word_index_o,
  output logic              in_range_o,
  output logic              unsupported_o
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] step;

  // Byte offset from the memory base; wraps naturally below BASE_ADDR,
  // which the explicit >= test below filters out.
  assign offset = addr_i - BASE_ADDR;
  assign step   = ADDR_W'(1) << size_i;

  assign next_addr_o   = (burst_i == BURST_FIXED) ? addr_i : addr_i + step;
  assign word_index_o  = offset[IDX_W+1:2];
  assign in_range_o    = (addr_i >= BASE_ADDR) &&
                         ((offset >> 2) < ADDR_W'(MEM_WORDS));
  // WRAP, the reserved encoding and anything wider than a word are refused.
  assign unsupported_o = (burst_i == BURST_WRAP) || (burst_i == 2'b11) ||
                         (size_i > 3'd2);

endmodule
`default_nettype wire

// File: rtl/axi4_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_slave_mem
//  Description : AXI4 responder backed by a word-addressed memory. One read
//                and one write burst in flight concurrently; FIXED/INCR only.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_slave_mem
  import axi4_slave_mem_pkg::*;
#(
  parameter int                        AXI_ID_WIDTH   = AXI_ID_WIDTH_DEF,
  parameter int                        AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        MEM_WORDS      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        READ_LATENCY   = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi4_slave_mem_if.slave   s_axi,
  output logic [7:0]        err_count
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Read channel state
  rd_state_e                 rd_state_q;
  logic                      arready_q, rvalid_q;
  logic [AXI_ID_WIDTH-1:0]   rid_q;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]                rlen_q, rbeat_q;
  logic [2:0]                rsize_q;
  logic [1:0]                rburst_q;
  logic [LAT_W-1:0]          rlat_q;

  // Write channel state
  wr_state_e                 wr_state_q;
  logic                      awready_q, wready_q, bvalid_q, werr_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]                wlen_q, wbeat_q;
  logic [2:0]                wsize_q;
  logic [1:0]                wburst_q, bresp_q;

  logic [7:0]                err_q, err_d;

  logic [AXI_ADDR_WIDTH-1:0] rd_next, wr_next;
  logic [IDX_W-1:0]          rd_idx, wr_idx;
  logic                      rd_in, rd_unsup, wr_in, wr_unsup;
  logic                      rd_ok, wr_ok, w_hs, w_last_exp, w_beat_err;
  logic                      r_err_hs, b_err_hs;
  logic [8:0]                err_sum;

  axi_burst_addr_gen #(
    .ADDR_W    (AXI_ADDR_WIDTH),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_rd_addr (
    .addr_i        (raddr_q),
    .size_i        (rsize_q),
    .burst_i       (rburst_q),
    .next_addr_o   (rd_next),
    .word_index_o  (rd_idx),
    .in_range_o    (rd_in),
    .unsupported_o (rd_unsup)
  );

  axi_burst_addr_gen #(
    .ADDR_W    (AXI_ADDR_WIDTH),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr_addr (
    .addr_i        (waddr_q),
    .size_i        (wsize_q),
    .burst_i       (wburst_q),
    .next_addr_o   (wr_next),
    .word_index_o  (wr_idx),
    .in_range_o    (wr_in),
    .unsupported_o (wr_unsup)
  );

  // Read data comes straight from the array so a write committed on one edge
  // is visible on the next cycle; it only depends on held registers, so it is
  // stable while the master stalls.
  assign rd_ok          = rd_in && !rd_unsup;
  assign s_axi.arready  = arready_q;
  assign s_axi.rvalid   = rvalid_q;
  assign s_axi.rid      = rid_q;
  assign s_axi.rdata    = (rvalid_q && rd_ok) ? mem_q[rd_idx] : '0;
  assign s_axi.rresp    = (rvalid_q && !rd_ok) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rlast    = rvalid_q && (rbeat_q == rlen_q);

  assign wr_ok          = wr_in && !wr_unsup;
  assign w_hs           = (wr_state_q == W_DATA) && s_axi.wvalid;
  assign w_last_exp     = (wbeat_q == wlen_q);
  assign w_beat_err     = !wr_ok || (s_axi.wlast != w_last_exp);
  assign s_axi.awready  = awready_q;
  assign s_axi.wready   = wready_q;
  assign s_axi.bvalid   = bvalid_q;
  assign s_axi.bid      = bid_q;
  assign s_axi.bresp    = bresp_q;

  // Read FSM: capture AR, wait out the read latency, then stream beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rbeat_q    <= '0;
      rlat_q     <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (s_axi.arvalid) begin
            rid_q     <= s_axi.arid;
            raddr_q   <= s_axi.araddr;
            rlen_q    <= s_axi.arlen;
            rsize_q   <= s_axi.arsize;
            rburst_q  <= s_axi.arburst;
            rbeat_q   <= '0;
            rlat_q    <= '0;
            arready_q <= 1'b0;
            if (READ_LATENCY == 0) begin
              rd_state_q <= R_DATA;
              rvalid_q   <= 1'b1;
            end else begin
              rd_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (int'(rlat_q) + 1 >= READ_LATENCY) begin
            rd_state_q <= R_DATA;
            rvalid_q   <= 1'b1;
          end else begin
            rlat_q <= rlat_q + 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rbeat_q <= rbeat_q + 8'd1;
            raddr_q <= rd_next;
            if (rbeat_q == rlen_q) begin
              rd_state_q <= R_IDLE;
              rvalid_q   <= 1'b0;
              arready_q  <= 1'b1;
            end
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Write FSM: completion is decided by beat count; a wrong wlast only
  // poisons the response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      werr_q     <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (s_axi.awvalid) begin
            bid_q      <= s_axi.awid;
            waddr_q    <= s_axi.awaddr;
            wlen_q     <= s_axi.awlen;
            wsize_q    <= s_axi.awsize;
            wburst_q   <= s_axi.awburst;
            wbeat_q    <= '0;
            werr_q     <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid) begin
            wbeat_q <= wbeat_q + 8'd1;
            waddr_q <= wr_next;
            werr_q  <= werr_q | w_beat_err;
            if (w_last_exp) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Byte-lane writes for accepted, in-range, supported beats only.
  always_ff @(posedge aclk) begin
    if (w_hs && wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi.wstrb[i]) begin
          mem_q[wr_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
        end
      end
    end
  end

  // One R and one B error can retire in the same cycle, hence a 9-bit sum.
  assign r_err_hs  = rvalid_q && s_axi.rready && !rd_ok;
  assign b_err_hs  = bvalid_q && s_axi.bready && (bresp_q == RESP_SLVERR);
  assign err_sum   = 9'(err_q) + 9'(r_err_hs) + 9'(b_err_hs);
  assign err_d     = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  assign err_count = err_q;

  // Saturating SLVERR counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_slave_mem
//  Description : Scoreboard bench for axi4_slave_mem: reference memory model,
//                expected read beats queued at request time, popped on return.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_mem;

  localparam int MEM_BYTES = 4096;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] err_count;

  axi4_slave_mem_if #(.ID_W(4), .ADDR_W(32)) s_axi ();

  axi4_slave_mem dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_axi     (s_axi),
    .err_count (err_count)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  rbeat_t      exp_q[$];
  rbeat_t      obs_q[$];
  rbeat_t      held_q[$];
  rbeat_t      cur_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] model [int];

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
    return model.exists(idx) ? model[idx] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] w;
    w = model_read(addr);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[int'(addr >> 2)] = w;
  endfunction

  function automatic void push_exp(input logic [3:0] id, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic [31:0] a;
    bit          unsup;
    rbeat_t      e;
    a     = addr;
    unsup = (burst == 2'b10) || (burst == 2'b11) || (size > 3'd2);
    for (int b = 0; b <= int'(len); b++) begin
      if (!unsup && a < MEM_BYTES) e = {model_read(a), 2'b00, b == int'(len), id};
      else                         e = {32'h0, 2'b10, b == int'(len), id};
      exp_q.push_back(e);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
  endfunction

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit stall, output int lat);
    int       guard;
    int       k;
    bit       hs, done, seen, prev_stalled;
    rbeat_t   cur, prev;
    bit [3:0] pat;
    pat = 4'b1001;
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
    s_axi.arsize = size; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
    guard = 0; hs = 1'b0;
    while (!hs && guard < 100) begin
      hs = s_axi.arready;
      @(posedge aclk); #1;
      guard++;
    end
    s_axi.arvalid = 1'b0;
    lat = 0; k = 0; done = 1'b0; seen = 1'b0; prev_stalled = 1'b0; prev = '0;
    while (hs && !done && guard < 400) begin
      s_axi.rready = stall ? pat[k % 4] : 1'b1;
      #1;
      if (s_axi.rvalid) begin
        seen = 1'b1;
        cur  = {s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.rid};
        if (prev_stalled) begin
          held_q.push_back(prev);
          cur_q.push_back(cur);
        end
        if (s_axi.rready) begin
          obs_q.push_back(cur);
          done = s_axi.rlast;
          prev_stalled = 1'b0;
        end else begin
          prev = cur;
          prev_stalled = 1'b1;
        end
        k++;
      end else if (!seen) begin
        lat++;
      end
      @(posedge aclk); #1;
      guard++;
    end
    s_axi.rready = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, output logic [1:0] bresp,
                             output logic [3:0] bid, output bit ok);
    int guard;
    bit hs;
    ok = 1'b1; bresp = 2'bxx; bid = 4'hx;
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len;
    s_axi.awsize = size; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
    guard = 0; hs = 1'b0;
    while (!hs && guard < 100) begin
      hs = s_axi.awready;
      @(posedge aclk); #1;
      guard++;
    end
    s_axi.awvalid = 1'b0;
    if (!hs) ok = 1'b0;
    for (int b = 0; ok && b <= int'(len); b++) begin
      s_axi.wdata = wd_q[b]; s_axi.wstrb = ws_q[b];
      s_axi.wlast = (b == int'(len)); s_axi.wvalid = 1'b1;
      hs = 1'b0;
      while (!hs && guard < 200) begin
        hs = s_axi.wready;
        @(posedge aclk); #1;
        guard++;
      end
      if (!hs) ok = 1'b0;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    s_axi.bready = 1'b1;
    hs = 1'b0;
    while (ok && !hs && guard < 300) begin
      hs = s_axi.bvalid;
      if (hs) begin bresp = s_axi.bresp; bid = s_axi.bid; end
      @(posedge aclk); #1;
      guard++;
    end
    if (!hs) ok = 1'b0;
    s_axi.bready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if ({s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.rlast,
         s_axi.bvalid, s_axi.rresp, s_axi.bresp, s_axi.rid, s_axi.bid, s_axi.rdata,
         err_count} !== {3'b110, 3'b000, 12'h0, 32'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_in got arready=%b awready=%b wready=%b rvalid=%b bvalid=%b err=%0d",
               s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.bvalid, err_count);
    end
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    n_checks++;
    if ({s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.bvalid, err_count}
        !== {5'b11000, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_idle got arready=%b awready=%b wready=%b rvalid=%b bvalid=%b err=%0d",
               s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.bvalid, err_count);
    end
  endtask

  task automatic test_incr;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    wd_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    ws_q = {4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(4'h3, 32'h100, 8'd3, 3'd2, 2'b01, br, bi, ok);
    for (int b = 0; b < 4; b++) model_write(32'h100 + 4*b, wd_q[b], 4'hF);
    n_checks++;
    if ({ok, br, bi} !== {1'b1, 2'b00, 4'h3}) begin
      n_fail++;
      $display("FAIL incr_bresp got ok=%b bresp=%b bid=%h exp ok=1 bresp=00 bid=3", ok, br, bi);
    end
    push_exp(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
    read_burst(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, lat);
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL incr_latency got %0d exp 2", lat);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL incr_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL incr_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_strobe;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    wd_q = {32'h11223344}; ws_q = {4'hF};
    write_burst(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, br, bi, ok);
    model_write(32'h40, 32'h11223344, 4'hF);
    wd_q = {32'hAABBCCDD}; ws_q = {4'b0101};
    write_burst(4'h2, 32'h40, 8'd0, 3'd2, 2'b01, br, bi, ok);
    model_write(32'h40, 32'hAABBCCDD, 4'b0101);
    n_checks++;
    if ({ok, br, bi} !== {1'b1, 2'b00, 4'h2}) begin
      n_fail++;
      $display("FAIL strobe_bresp got ok=%b bresp=%b bid=%h exp ok=1 bresp=00 bid=2", ok, br, bi);
    end
    push_exp(4'h7, 32'h40, 8'd0, 3'd2, 2'b01);
    read_burst(4'h7, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, lat);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL strobe_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL strobe_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fixed;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    wd_q = {32'hCAFE0020}; ws_q = {4'hF};
    write_burst(4'h4, 32'h20, 8'd0, 3'd2, 2'b01, br, bi, ok);
    model_write(32'h20, 32'hCAFE0020, 4'hF);
    push_exp(4'h6, 32'h20, 8'd3, 3'd2, 2'b00);
    read_burst(4'h6, 32'h20, 8'd3, 3'd2, 2'b00, 1'b0, lat);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL fixed_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL fixed_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_oob;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    wd_q = {32'h5A5A0FFC}; ws_q = {4'hF};
    write_burst(4'h8, 32'hFFC, 8'd0, 3'd2, 2'b01, br, bi, ok);
    model_write(32'hFFC, 32'h5A5A0FFC, 4'hF);
    push_exp(4'h9, 32'hFFC, 8'd1, 3'd2, 2'b01);
    read_burst(4'h9, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b0, lat);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL oob_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL oob_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL oob_errcount got %0d exp 1", err_count);
    end
  endtask

  task automatic test_unsupported;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    wd_q = {32'hDEADBEEF}; ws_q = {4'hF};
    write_burst(4'hA, 32'h40, 8'd0, 3'd2, 2'b10, br, bi, ok);
    n_checks++;
    if ({ok, br, bi, err_count} !== {1'b1, 2'b10, 4'hA, 8'd2}) begin
      n_fail++;
      $display("FAIL wrap_write got ok=%b bresp=%b bid=%h err=%0d exp ok=1 bresp=10 bid=a err=2",
               ok, br, bi, err_count);
    end
    push_exp(4'hB, 32'h40, 8'd1, 3'd2, 2'b10);
    read_burst(4'hB, 32'h40, 8'd1, 3'd2, 2'b10, 1'b0, lat);
    push_exp(4'hC, 32'h40, 8'd0, 3'd3, 2'b01);
    read_burst(4'hC, 32'h40, 8'd0, 3'd3, 2'b01, 1'b0, lat);
    push_exp(4'hD, 32'h40, 8'd0, 3'd2, 2'b01);
    read_burst(4'hD, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, lat);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL unsup_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL unsup_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (err_count !== 8'd5) begin
      n_fail++;
      $display("FAIL unsup_errcount got %0d exp 5", err_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    held_q.delete(); cur_q.delete();
    wd_q = {32'hB0, 32'hB1, 32'hB2, 32'hB3};
    ws_q = {4'hF, 4'hF, 4'hF, 4'hF};
    for (int b = 0; b < 4; b++) model_write(32'h200 + 4*b, wd_q[b], 4'hF);
    push_exp(4'hE, 32'h100, 8'd3, 3'd2, 2'b01);
    fork
      read_burst(4'hE, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1, lat);
      write_burst(4'hF, 32'h200, 8'd3, 3'd2, 2'b01, br, bi, ok);
    join
    n_checks++;
    if ({ok, br, bi} !== {1'b1, 2'b00, 4'hF}) begin
      n_fail++;
      $display("FAIL b2b_bresp got ok=%b bresp=%b bid=%h exp ok=1 bresp=00 bid=f", ok, br, bi);
    end
    n_checks++;
    if (held_q.size() == 0) begin
      n_fail++;
      $display("FAIL b2b_stalls got 0 stall pairs exp >0");
    end
    while (held_q.size() > 0 && cur_q.size() > 0) begin
      e = held_q.pop_front(); o = cur_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_stall_stable got %h exp %h", o, e); end
    end
    push_exp(4'h2, 32'h200, 8'd3, 3'd2, 2'b01);
    read_burst(4'h2, 32'h200, 8'd3, 3'd2, 2'b01, 1'b0, lat);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_write;
    logic [1:0] br; logic [3:0] bi; bit ok; int lat;
    rbeat_t e, o;
    @(posedge aclk); #1;
    s_axi.awid = 4'h7; s_axi.awaddr = 32'h300; s_axi.awlen = 8'd3;
    s_axi.awsize = 3'd2; s_axi.awburst = 2'b01; s_axi.awvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0;
    s_axi.wdata = 32'h77770000; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    #2 aresetn = 1'b0;
    #1;
    n_checks++;
    if ({s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.rlast,
         s_axi.bvalid, s_axi.rresp, s_axi.bresp, s_axi.rid, s_axi.bid, s_axi.rdata,
         err_count} !== {3'b110, 3'b000, 12'h0, 32'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL midreset_async got arready=%b awready=%b wready=%b bvalid=%b bid=%h err=%0d",
               s_axi.arready, s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bid, err_count);
    end
    s_axi.wvalid = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    n_checks++;
    if ({s_axi.arready, s_axi.awready, s_axi.wready} !== 3'b110) begin
      n_fail++;
      $display("FAIL midreset_ready got arready=%b awready=%b wready=%b exp 1 1 0",
               s_axi.arready, s_axi.awready, s_axi.wready);
    end
    wd_q = {32'h12345678}; ws_q = {4'hF};
    write_burst(4'h3, 32'h300, 8'd0, 3'd2, 2'b01, br, bi, ok);
    model_write(32'h300, 32'h12345678, 4'hF);
    n_checks++;
    if ({ok, br, bi} !== {1'b1, 2'b00, 4'h3}) begin
      n_fail++;
      $display("FAIL midreset_write got ok=%b bresp=%b bid=%h exp ok=1 bresp=00 bid=3", ok, br, bi);
    end
    push_exp(4'h4, 32'h300, 8'd0, 3'd2, 2'b01);
    read_burst(4'h4, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0, lat);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_beats got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL midreset_rbeat got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    aresetn = 1'b0;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0;
    s_axi.arburst = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0;
    s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    test_reset();
    test_incr();
    test_strobe();
    test_fixed();
    test_oob();
    test_unsupported();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
